// File: rtl/mips_pkg.sv
// Shared MIPS fetch-stage definitions: instruction size and the next-PC source encoding.
package mips_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_PCW = 3'd1,
        SEL_BR  = 3'd2,
        SEL_JMP = 3'd3,
        SEL_RET = 3'd4
    } next_sel_e;

    // Word-aligned addresses have both low bits clear.
    function automatic logic word_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control unit (master) and the PC sequencer (slave).
// Level-based control: every input is sampled on each rising edge; there is no valid/ready handshake.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 16
);
    logic              stall;
    logic              branch;
    logic [OFF_W-1:0]  branch_offset;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] ret_fallback;
    logic              pc_write;
    logic [ADDR_W-1:0] pc_write_value;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;
    logic              ras_underflow;
    logic              misaligned;

    modport master (
        output stall, branch, branch_offset, jump, jump_target, call, ret,
               ret_fallback, pc_write, pc_write_value,
        input  pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow, misaligned
    );

    modport slave (
        input  stall, branch, branch_offset, jump, jump_target, call, ret,
               ret_fallback, pc_write, pc_write_value,
        output pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow, misaligned
    );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry and sets a sticky overflow.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] push_slot;

    assign push_slot = top_ptr + PTR_ONE;
    assign top       = mem[top_ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (push) begin
            top_ptr <= push_slot;
            if (full) overflow <= 1'b1;
            else      count    <= count + CNT_ONE;
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PTR_ONE;
            count   <= count - CNT_ONE;
        end
    end

    // Storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[push_slot] <= data_in;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: priority next-PC select (ret > jump > branch > pc_write > pc+4),
// return-address stack for call/ret, and word alignment of every selected target.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                OFF_W        = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 4
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  bus
);
    next_sel_e         sel;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;
    logic              push;
    logic              pop;
    logic              misaligned_q;
    logic              underflow_q;

    assign pc_plus4      = pc_q + ADDR_W'(INSTR_BYTES);
    assign branch_target = pc_plus4 +
        ({{(ADDR_W-OFF_W){bus.branch_offset[OFF_W-1]}}, bus.branch_offset} << 2);

    always_comb begin
        sel = SEL_SEQ;
        if      (bus.ret)      sel = SEL_RET;
        else if (bus.jump)     sel = SEL_JMP;
        else if (bus.branch)   sel = SEL_BR;
        else if (bus.pc_write) sel = SEL_PCW;
    end

    always_comb begin
        target = pc_plus4;
        case (sel)
            SEL_RET: target = ras_empty ? bus.ret_fallback : ras_top;
            SEL_JMP: target = bus.jump_target;
            SEL_BR:  target = branch_target;
            SEL_PCW: target = bus.pc_write_value;
            default: target = pc_plus4;
        endcase
    end

    // The return address pushed on a call is the pc+4 of the calling instruction.
    assign push = !stall_or_rst() && (sel == SEL_JMP) && bus.call;
    assign pop  = !stall_or_rst() && (sel == SEL_RET) && !ras_empty;

    function automatic logic stall_or_rst();
        return bus.stall || rst;
    endfunction

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (pc_plus4),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full),
        .overflow (ras_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (bus.stall) begin
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= {target[ADDR_W-1:2], 2'b00};
            misaligned_q <= word_misaligned(target[1:0]);
            underflow_q  <= (sel == SEL_RET) && ras_empty;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_overflow  = ras_overflow;
    assign bus.ras_underflow = underflow_q;
    assign bus.misaligned    = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch wrap, call/ret, RAS overflow/underflow,
// stall, select priority, alignment and reset during stall.
module tb_pc_sequencer;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [ADDR_W-1:0] exp_q[$];

    pc_sequencer_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

    pc_sequencer #(
        .ADDR_W       (ADDR_W),
        .OFF_W        (OFF_W),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ADDR_W-1:0] got, input logic [ADDR_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.stall          = 1'b0;
        bus.branch         = 1'b0;
        bus.branch_offset  = '0;
        bus.jump           = 1'b0;
        bus.jump_target    = '0;
        bus.call           = 1'b0;
        bus.ret            = 1'b0;
        bus.ret_fallback   = 32'h0000_ABC0;
        bus.pc_write       = 1'b0;
        bus.pc_write_value = '0;
    endtask

    // Apply current inputs for one edge, then sample #1 after it.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_pc(input logic [ADDR_W-1:0] v);
        bus.pc_write = 1'b1;
        bus.pc_write_value = v;
        step();
    endtask

    task automatic do_call(input logic [ADDR_W-1:0] t);
        bus.jump = 1'b1;
        bus.call = 1'b1;
        bus.jump_target = t;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1'b1;

        // 1: reset for two cycles, then free-running fetch
        step();
        check("rst_pc0", bus.pc, 32'h0);
        step();
        check("rst_pc1", bus.pc, 32'h0);
        check("rst_empty", 32'(bus.ras_empty), 32'h1);
        check("rst_ovf", 32'(bus.ras_overflow), 32'h0);
        rst = 1'b0;
        exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), bus.pc, exp_q.pop_front());
        end
        check("seq_plus4", bus.pc_plus4, 32'h14);

        // 2: branch backwards and branch wrapping past the top of memory
        load_pc(32'h100);
        bus.branch = 1'b1;
        bus.branch_offset = 16'hFFFE;
        step();
        check("br_back", bus.pc, 32'hFC);
        load_pc(32'hFFFF_FFF0);
        bus.branch = 1'b1;
        bus.branch_offset = 16'h7FFF;
        step();
        check("br_wrap", bus.pc, 32'h0001_FFF0);
        check("br_aligned", 32'(bus.misaligned), 32'h0);

        // 3: single call and return
        load_pc(32'h40);
        do_call(32'h200);
        check("call_pc", bus.pc, 32'h200);
        check("call_nonempty", 32'(bus.ras_empty), 32'h0);
        bus.ret = 1'b1;
        step();
        check("ret_pc", bus.pc, 32'h44);
        check("ret_empty", 32'(bus.ras_empty), 32'h1);

        // 4: five nested calls overflow a 4-deep stack
        load_pc(32'h1000);
        for (int i = 0; i < 5; i++) do_call(32'h2000 + 32'(i) * 32'h1000);
        check("nest_pc", bus.pc, 32'h6000);
        check("nest_full", 32'(bus.ras_full), 32'h1);
        check("nest_ovf", 32'(bus.ras_overflow), 32'h1);
        exp_q = '{32'h5004, 32'h4004, 32'h3004, 32'h2004};
        for (int i = 0; i < 4; i++) begin
            bus.ret = 1'b1;
            step();
            check($sformatf("nest_ret%0d", i), bus.pc, exp_q.pop_front());
            check($sformatf("nest_ret_uf%0d", i), 32'(bus.ras_underflow), 32'h0);
        end
        check("nest_drained", 32'(bus.ras_empty), 32'h1);
        bus.ret = 1'b1;
        step();
        check("uf_fallback", bus.pc, 32'h0000_ABC0);
        check("uf_pulse", 32'(bus.ras_underflow), 32'h1);
        step();
        check("uf_clear", 32'(bus.ras_underflow), 32'h0);
        check("ovf_sticky", 32'(bus.ras_overflow), 32'h1);

        // 5: stall freezes pc despite a jump; ret beats jump and branch without pushing
        load_pc(32'h300);
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;
            bus.jump = 1'b1;
            bus.jump_target = 32'h800;
            step();
            check($sformatf("stall_pc%0d", i), bus.pc, 32'h300);
        end
        do_call(32'h500);
        bus.ret = 1'b1;
        bus.jump = 1'b1;
        bus.call = 1'b1;
        bus.jump_target = 32'h900;
        bus.branch = 1'b1;
        bus.branch_offset = 16'h0010;
        step();
        check("prio_ret_pc", bus.pc, 32'h304);
        check("prio_no_push", 32'(bus.ras_empty), 32'h1);

        // 6: misaligned jump target, then reset asserted during a stall with the RAS in use
        bus.jump = 1'b1;
        bus.jump_target = 32'h203;
        step();
        check("mis_pc", bus.pc, 32'h200);
        check("mis_pulse", 32'(bus.misaligned), 32'h1);
        step();
        check("mis_next_pc", bus.pc, 32'h204);
        check("mis_clear", 32'(bus.misaligned), 32'h0);
        do_call(32'h600);
        check("pre_rst_nonempty", 32'(bus.ras_empty), 32'h0);
        bus.stall = 1'b1;
        rst = 1'b1;
        step();
        check("rst_stall_pc", bus.pc, 32'h0);
        check("rst_stall_empty", 32'(bus.ras_empty), 32'h1);
        check("rst_stall_ovf", 32'(bus.ras_overflow), 32'h0);
        rst = 1'b0;
        bus.ret = 1'b1;
        step();
        check("post_rst_ret", bus.pc, 32'h0000_ABC0);
        check("post_rst_uf", 32'(bus.ras_underflow), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
